scanner_link_tx: RTL and testbench
==================================

# scanner_link_tx

Local scanner buffer and serial frame transmitter. It sits directly upstream of the transfer center and drives its `dataIn` line. Scan samples are captured into an internal FIFO, and buffer-fill status codes (1–4) are announced as thresholds are crossed. On command, the buffer is drained as "data follows" header + data byte frame pairs. Frames are 8 bits, MSB first, one bit per clock, aligned to reset.

## Interface
- `DEPTH`, 10: FIFO entries, legal range 2..15.
- `clk`  in  1  system clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `localScannerIn`  in  2  command from transfer center: 2'b01 start scanning, 2'b10 flush, others no-op.
- `sampleValid`  in  1  scan sample strobe.
- `sampleData`  in  8  scan sample byte.
- `readyForTransferIn`  in  1  downstream permits data frames.
- `dataOut`  out  1  serial frame bit, registered.
- `frameStart`  out  1  high while `dataOut` carries bit 7 of a frame.
- `level`  out  4  FIFO occupancy.
- `overflow`  out  1  sticky; a sample was dropped while full.
- `transferActive`  out  1  drain in progress.

## Operation
- Reset values:
  - `dataOut`, `frameStart`, `level`, `overflow`, `transferActive` = 0.
  - FIFO empty; scanning off; pending status flags cleared; bit counter = 0.
- Commands, applied every cycle:
  - 2'b01 sets scanning.
  - 2'b10 clears scanning and sets `transferActive`.
- Sample capture: `sampleValid` && scanning && !full pushes `sampleData`. If full, the sample is dropped and `overflow` is set.
- Status thresholds: T50 = DEPTH*5/10, T80 = DEPTH*8/10, T90 = DEPTH*9/10, TF = DEPTH (integer division).
  - A push raising occupancy to T50/T80/T90/TF sets pending flag for code 1/2/3/4 respectively.
  - If thresholds coincide, all matching flags are set.
  - A push and pop in the same cycle does not trigger a crossing.
- Auto-transfer: occupancy == DEPTH && `readyForTransferIn` sets `transferActive`.
- Frame selection happens at each boundary (bit counter == 0), in priority order:
  1. Pending data byte: pop the FIFO head, send it.
  2. Lowest-numbered pending status flag: send its code and clear that flag.
  3. `transferActive` && `readyForTransferIn` && FIFO non-empty: send header 8'd7 and arm the data byte for the next frame.
  4. Otherwise send idle 8'd0.
- Transfer end: when the FIFO is empty and no data byte is pending, `transferActive` clears.
- An armed data byte is always sent in the frame immediately following its header. `readyForTransferIn` is sampled only when choosing a header.
- Reset mid-frame aborts the frame. `dataOut` returns to 0 the following cycle and frame alignment restarts.

## Timing
- Bit counter is 3 bits, increments every non-reset cycle, and wraps 7 → 0.
- Frame k occupies cycles 8k..8k+7, counted from the first rising edge with `rst` low.
- `dataOut` in cycle 8k+j = frame bit 7−j, registered. `frameStart` is high only in cycle 8k.
- Status latency: a push crossing a threshold in frame k emits its code no earlier than frame k+1.
- Header-to-data spacing is exactly 8 cycles, with no idle frame between them.
- `level` updates the cycle after a push or pop.

## Configuration
- `SCANNER_ASCII_EN` defined:
  - Headers are 8'd8 ("ASCII data follows").
  - Data bytes are sent as `data & 8'h7F`.
- Undefined:
  - Headers are 8'd7 ("binary data follows").
  - Data bytes are sent unmodified.

## Test plan
- Reset, then 32 idle cycles → `dataOut` = 0 throughout; `frameStart` high at cycles 0, 8, 16, 24.
- Command 01, then push 5 samples → next boundary sends 8'h01 (bits 0,0,0,0,0,0,0,1); `level` = 5.
- Push 10 samples with `readyForTransferIn` = 0 → codes 1, 2, 3, 4 each sent once, in order. 11th push sets `overflow`; `level` stays 10.
- Full FIFO, raise `readyForTransferIn` → frame pairs 07,s0,07,s1,…,07,s9, then idle 00; `transferActive` falls after s9.
- Flush command with 3 entries, `readyForTransferIn` dropped after the first header → data byte still follows; afterwards idle frames until ready returns, then the remaining 2 pairs.
- With `SCANNER_ASCII_EN`, sample 8'hC1 flushed → frames 08, 41.

Source files
------------

// File: rtl/scanner_link_tx_if.sv
// Scanner-to-transfer-center link: sample capture inputs, flow control and serial frame outputs.
// The slave modport is the transmitter; the master modport is whoever drives it.
interface scanner_link_tx_if;
    logic [1:0] localScannerIn;
    logic       sampleValid;
    logic [7:0] sampleData;
    logic       readyForTransferIn;
    logic       dataOut;
    logic       frameStart;
    logic [3:0] level;
    logic       overflow;
    logic       transferActive;

    modport master (
        output localScannerIn, sampleValid, sampleData, readyForTransferIn,
        input  dataOut, frameStart, level, overflow, transferActive
    );

    modport slave (
        input  localScannerIn, sampleValid, sampleData, readyForTransferIn,
        output dataOut, frameStart, level, overflow, transferActive
    );
endinterface

// File: rtl/scanner_link_tx.sv
// Scanner sample FIFO plus 8-bit MSB-first serial framer (status codes, header + data pairs).
// One-cycle registered output; samples dropped (sticky overflow) when full. SCANNER_ASCII_EN selects ASCII framing.
module scanner_link_tx #(
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    scanner_link_tx_if.slave link
);

    localparam logic [3:0] T50 = 4'(DEPTH * 5 / 10);
    localparam logic [3:0] T80 = 4'(DEPTH * 8 / 10);
    localparam logic [3:0] T90 = 4'(DEPTH * 9 / 10);
    localparam logic [3:0] TF  = 4'(DEPTH);

`ifdef SCANNER_ASCII_EN
    localparam logic [7:0] HDR   = 8'd8;
    localparam logic [7:0] DMASK = 8'h7F;
`else
    localparam logic [7:0] HDR   = 8'd7;
    localparam logic [7:0] DMASK = 8'hFF;
`endif

    logic [7:0] mem [DEPTH];
    logic [3:0] wrPtr, rdPtr, count, nextCount;
    logic [3:0] flags, flagSet, flagClr;
    logic [2:0] bitCnt;
    logic [7:0] shReg, frame;
    logic       scanning, dataPending, active, ovf, dataQ, startQ;
    logic       full, empty, push, pop, arm;

    assign full  = (count == TF);
    assign empty = (count == 4'd0);
    assign push  = link.sampleValid && scanning && !full;

    // Frame choice only matters on a boundary; the chosen byte is loaded whole into the shifter.
    always_comb begin
        frame   = 8'd0;
        pop     = 1'b0;
        arm     = 1'b0;
        flagClr = 4'b0000;
        if (bitCnt == 3'd0) begin
            if (dataPending) begin
                pop   = 1'b1;
                frame = mem[rdPtr] & DMASK;
            end else if (flags[0]) begin
                frame   = 8'd1;
                flagClr = 4'b0001;
            end else if (flags[1]) begin
                frame   = 8'd2;
                flagClr = 4'b0010;
            end else if (flags[2]) begin
                frame   = 8'd3;
                flagClr = 4'b0100;
            end else if (flags[3]) begin
                frame   = 8'd4;
                flagClr = 4'b1000;
            end else if (active && link.readyForTransferIn && !empty) begin
                frame = HDR;
                arm   = 1'b1;
            end
        end
    end

    // Only a net push (no simultaneous pop) counts as a threshold crossing.
    always_comb begin
        nextCount = count;
        flagSet   = 4'b0000;
        if (push && !pop) begin
            nextCount = count + 4'd1;
            flagSet   = {nextCount == TF, nextCount == T90, nextCount == T80, nextCount == T50};
        end else if (pop && !push) begin
            nextCount = count - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= link.sampleData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitCnt      <= 3'd0;
            shReg       <= 8'd0;
            dataQ       <= 1'b0;
            startQ      <= 1'b0;
            count       <= 4'd0;
            wrPtr       <= 4'd0;
            rdPtr       <= 4'd0;
            flags       <= 4'b0000;
            dataPending <= 1'b0;
            scanning    <= 1'b0;
            ovf         <= 1'b0;
            active      <= 1'b0;
        end else begin
            bitCnt <= bitCnt + 3'd1;
            if (bitCnt == 3'd0) begin
                dataQ  <= frame[7];
                shReg  <= {frame[6:0], 1'b0};
                startQ <= 1'b1;
            end else begin
                dataQ  <= shReg[7];
                shReg  <= {shReg[6:0], 1'b0};
                startQ <= 1'b0;
            end

            count <= nextCount;
            if (push) wrPtr <= (wrPtr == TF - 4'd1) ? 4'd0 : wrPtr + 4'd1;
            if (pop)  rdPtr <= (rdPtr == TF - 4'd1) ? 4'd0 : rdPtr + 4'd1;
            flags <= (flags & ~flagClr) | flagSet;

            if (arm)      dataPending <= 1'b1;
            else if (pop) dataPending <= 1'b0;

            if (link.localScannerIn == 2'b01)      scanning <= 1'b1;
            else if (link.localScannerIn == 2'b10) scanning <= 1'b0;

            if (link.sampleValid && scanning && full) ovf <= 1'b1;

            // A start request in the same cycle as the end condition wins.
            if (empty && !dataPending) active <= 1'b0;
            if (link.localScannerIn == 2'b10 || (full && link.readyForTransferIn)) active <= 1'b1;
        end
    end

    assign link.dataOut        = dataQ;
    assign link.frameStart     = startQ;
    assign link.level          = count;
    assign link.overflow       = ovf;
    assign link.transferActive = active;

endmodule

// File: tb/tb_scanner_link_tx.sv
// Directed bench for scanner_link_tx: frames are deserialised from dataOut and compared to hand-built sequences.
module tb_scanner_link_tx;

`ifdef SCANNER_ASCII_EN
    localparam logic [7:0] HDR   = 8'd8;
    localparam logic [7:0] DMASK = 8'h7F;
`else
    localparam logic [7:0] HDR   = 8'd7;
    localparam logic [7:0] DMASK = 8'hFF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nBad = 0;
    int   cyc = -2;
    logic [7:0] sh = 8'd0;
    logic [7:0] frames[$];

    scanner_link_tx_if link();

    scanner_link_tx #(.DEPTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .link(link)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Cycle index: -1 while in reset, 0 on the first cycle after release.
    always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

    always @(negedge clk) begin
        if (cyc == -1) begin
            sh = 8'd0;
            checkVal("rst_dataOut", link.dataOut, 0);
            checkVal("rst_frameStart", link.frameStart, 0);
        end else if (cyc >= 0) begin
            sh = {sh[6:0], link.dataOut};
            checkVal("frameStart", link.frameStart, (cyc % 8 == 0) ? 1 : 0);
            if (cyc % 8 == 7) frames.push_back(sh);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic nextFrame(input bit skipIdle, output logic [7:0] f);
        int  waited = 0;
        bit  got = 0;
        f = 8'hEE;
        while (!got && waited < 400) begin
            if (frames.size() != 0) begin
                f = frames.pop_front();
                if (!(skipIdle && f == 8'd0)) got = 1;
            end else begin
                tick();
                waited++;
            end
        end
        checkVal("frame_arrived", got, 1);
    endtask

    task automatic expectFrame(input string tag, input bit skipIdle, input logic [7:0] exp);
        logic [7:0] f;
        nextFrame(skipIdle, f);
        checkVal(tag, f, exp);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pushSample(input logic [7:0] d);
        link.sampleValid = 1'b1;
        link.sampleData  = d;
        tick();
        link.sampleValid = 1'b0;
    endtask

    task automatic command(input logic [1:0] c);
        link.localScannerIn = c;
        tick();
        link.localScannerIn = 2'b00;
    endtask

    initial begin
        link.localScannerIn     = 2'b00;
        link.sampleValid        = 1'b0;
        link.sampleData         = 8'd0;
        link.readyForTransferIn = 1'b0;

        // Reset state and idle framing
        tick();
        tick();
        tick();
        checkVal("rst_level", link.level, 0);
        checkVal("rst_overflow", link.overflow, 0);
        checkVal("rst_active", link.transferActive, 0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        for (int i = 0; i < 4; i++) expectFrame("idle_frame", 0, 8'd0);

        // Five samples cross the 50% threshold -> code 1
        command(2'b01);
        pushSample(8'h11);
        checkVal("level_after_1", link.level, 1);
        for (int i = 2; i <= 5; i++) pushSample(8'(8'h10 + i));
        tick();
        checkVal("level_5", link.level, 5);
        expectFrame("code1_at_5", 1, 8'd1);

        // Fill to full: codes 1..4 in order, then overflow
        doReset();
        checkVal("level_after_rst", link.level, 0);
        command(2'b01);
        for (int i = 0; i < 10; i++) pushSample(8'(8'hA0 + i));
        tick();
        checkVal("level_full", link.level, 10);
        checkVal("no_overflow_yet", link.overflow, 0);
        pushSample(8'hFF);
        tick();
        checkVal("overflow_set", link.overflow, 1);
        checkVal("level_stays_full", link.level, 10);
        expectFrame("code1", 1, 8'd1);
        expectFrame("code2", 0, 8'd2);
        expectFrame("code3", 0, 8'd3);
        expectFrame("code4", 0, 8'd4);
        expectFrame("idle_after_codes", 0, 8'd0);
        expectFrame("idle_after_codes", 0, 8'd0);
        checkVal("no_auto_without_ready", link.transferActive, 0);

        // Auto-transfer of a full FIFO
        link.readyForTransferIn = 1'b1;
        tick();
        tick();
        tick();
        checkVal("auto_active", link.transferActive, 1);
        expectFrame("drain_hdr", 1, HDR);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) expectFrame("drain_hdr", 0, HDR);
            expectFrame("drain_data", 0, 8'(8'hA0 + i) & DMASK);
        end
        expectFrame("drain_idle", 0, 8'd0);
        checkVal("drain_active_off", link.transferActive, 0);
        checkVal("drain_level", link.level, 0);
        checkVal("overflow_sticky", link.overflow, 1);

        // Flush with ready dropped after the first header
        link.readyForTransferIn = 1'b0;
        doReset();
        command(2'b01);
        pushSample(8'hC1);
        pushSample(8'hB2);
        pushSample(8'hB3);
        link.readyForTransferIn = 1'b1;
        command(2'b10);
        checkVal("flush_active", link.transferActive, 1);
        expectFrame("flush_hdr1", 1, HDR);
        link.readyForTransferIn = 1'b0;
        expectFrame("flush_data1", 0, 8'hC1 & DMASK);
        expectFrame("flush_wait_idle", 0, 8'd0);
        expectFrame("flush_wait_idle", 0, 8'd0);
        checkVal("flush_still_active", link.transferActive, 1);
        checkVal("flush_level_2", link.level, 2);
        link.readyForTransferIn = 1'b1;
        expectFrame("flush_hdr2", 1, HDR);
        expectFrame("flush_data2", 0, 8'hB2 & DMASK);
        expectFrame("flush_hdr3", 0, HDR);
        expectFrame("flush_data3", 0, 8'hB3 & DMASK);
        expectFrame("flush_idle", 0, 8'd0);
        checkVal("flush_done", link.transferActive, 0);
        checkVal("flush_no_overflow", link.overflow, 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
